// File: rtl/qspi_host.sv
// Quad-SPI host: turns one request into a mode-0 quad transaction (CMD, ADDR,
// DUMMY, DATA) and returns a single response pulse when chip select rises.
module qspi_host #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        txn_valid_i,
  output logic        txn_ready_o,
  input  logic [7:0]  txn_cmd_i,
  input  logic        txn_has_addr_i,
  input  logic [31:0] txn_addr_i,
  input  logic        txn_dir_i,
  input  logic [3:0]  txn_dummy_i,
  input  logic [2:0]  txn_nbytes_i,
  input  logic [31:0] txn_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        spi_sce_o,
  output logic        spi_sck_o,
  output logic [3:0]  spi_io_o,
  input  logic [3:0]  spi_io_i,
  output logic        spi_io_oe
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(CS_IDLE + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(CS_IDLE);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_TAIL, S_CSHI
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idle;
  logic [3:0]    r_cnt;
  logic [31:0]   r_shift;
  logic [31:0]   r_rx;
  logic          r_has_addr;
  logic [31:0]   r_addr;
  logic          r_dir;
  logic [3:0]    r_dummy;
  logic [2:0]    r_nbytes;
  logic [31:0]   r_wdata;
  logic          r_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_sce;
  logic          r_sck;
  logic [3:0]    r_io;
  logic          r_oe;

  logic          w_accept;
  logic          w_div_last;
  state_t        w_nxt_state;
  logic [3:0]    w_nxt_cnt;
  logic [31:0]   w_nxt_shift;
  logic          w_nxt_oe;
  logic [31:0]   w_rx_aligned;

  assign w_accept   = (r_state == S_IDLE) && r_ready && txn_valid_i;
  assign w_div_last = (r_div == DIV_LAST);

  // Phase that follows the current one; empty phases are skipped here.
  always_comb begin
    w_nxt_state = S_TAIL;
    w_nxt_cnt   = 4'd0;
    w_nxt_shift = r_shift;
    w_nxt_oe    = r_oe;
    if (r_state == S_CMD && r_has_addr) begin
      w_nxt_state = S_ADDR;
      w_nxt_cnt   = 4'd8;
      w_nxt_shift = r_addr;
      w_nxt_oe    = 1'b1;
    end else if ((r_state == S_CMD || r_state == S_ADDR) && r_dir && (r_dummy != 4'd0)) begin
      w_nxt_state = S_DUMMY;
      w_nxt_cnt   = r_dummy;
      w_nxt_shift = 32'h0;
      w_nxt_oe    = 1'b0;
    end else if (r_state != S_DATA && r_nbytes != 3'd0) begin
      w_nxt_state = S_DATA;
      w_nxt_cnt   = {r_nbytes, 1'b0};
      w_nxt_shift = r_dir ? 32'h0 : r_wdata;
      w_nxt_oe    = ~r_dir;
    end
  end

  always_comb begin
    case (r_nbytes)
      3'd0:    w_rx_aligned = 32'h0;
      3'd1:    w_rx_aligned = {r_rx[7:0], 24'h0};
      3'd2:    w_rx_aligned = {r_rx[15:0], 16'h0};
      3'd3:    w_rx_aligned = {r_rx[23:0], 8'h0};
      default: w_rx_aligned = r_rx;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_idle      <= '0;
      r_cnt       <= 4'd0;
      r_shift     <= 32'h0;
      r_rx        <= 32'h0;
      r_has_addr  <= 1'b0;
      r_addr      <= 32'h0;
      r_dir       <= 1'b0;
      r_dummy     <= 4'd0;
      r_nbytes    <= 3'd0;
      r_wdata     <= 32'h0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_sce       <= 1'b1;
      r_sck       <= 1'b0;
      r_io        <= 4'h0;
      r_oe        <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_CMD;
            r_ready    <= 1'b0;
            r_sce      <= 1'b0;
            r_sck      <= 1'b0;
            r_div      <= '0;
            r_cnt      <= 4'd2;
            r_shift    <= {txn_cmd_i, 24'h0};
            r_io       <= txn_cmd_i[7:4];
            r_oe       <= 1'b1;
            r_rx       <= 32'h0;
            r_has_addr <= txn_has_addr_i;
            r_addr     <= txn_addr_i;
            r_dir      <= txn_dir_i;
            r_dummy    <= txn_dummy_i;
            r_nbytes   <= (txn_nbytes_i > 3'd4) ? 3'd4 : txn_nbytes_i;
            r_wdata    <= txn_wdata_i;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (w_div_last) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              // Rising SCK: the slave launched this nibble on the previous fall.
              if (r_state == S_DATA && r_dir)
                r_rx <= {r_rx[27:0], spi_io_i};
            end else if (r_cnt == 4'd1) begin
              r_state <= w_nxt_state;
              r_cnt   <= w_nxt_cnt;
              r_shift <= w_nxt_shift;
              r_io    <= w_nxt_shift[31:28];
              r_oe    <= w_nxt_oe;
            end else begin
              r_cnt   <= r_cnt - 4'd1;
              r_shift <= {r_shift[27:0], 4'h0};
              r_io    <= r_shift[27:24];
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_TAIL: begin
          // Hold CS low for one half-period after the last falling SCK edge.
          if (w_div_last) begin
            r_div       <= '0;
            r_state     <= S_CSHI;
            r_sce       <= 1'b1;
            r_oe        <= 1'b0;
            r_io        <= 4'h0;
            r_idle      <= IDLE_LOAD;
            r_rsp_valid <= 1'b1;
            if (r_dir)
              r_rsp_data <= w_rx_aligned;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_CSHI: begin
          if (r_idle == IW'(1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_idle <= r_idle - IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txn_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign spi_sce_o   = r_sce;
  assign spi_sck_o   = r_sck;
  assign spi_io_o    = r_io;
  assign spi_io_oe   = r_oe;

endmodule
